// File: rtl/ascon_msg_buf_pkg.sv
// ascon_msg_buf_pkg: shared FSM state, block geometry and byte-mask helpers for the ASCON message buffer.
package ascon_msg_buf_pkg;
  localparam int BYTES_PER_BLK = 8;
  localparam int WORDS_PER_BLK = 2;
  typedef enum logic [2:0] {IDLE, WAIT_REQ, RD_HI, RD_LO, HOLD, WR_HI, WR_LO} state_e;
  function automatic logic [3:0] blk_size_f(input logic last, input logic [2:0] rem);
    return last ? {1'b0, rem} : 4'(BYTES_PER_BLK);
  endfunction
  // Big-endian: byte 0 is bits 63:56, so valid bytes sit at the top.
  function automatic logic [63:0] blk_mask(input logic [3:0] size);
    return size[3] ? '1 : ~({64{1'b1}} >> {size[2:0], 3'b000});
  endfunction
endpackage

// File: rtl/ascon_msg_mem_1r1w.sv
// ascon_msg_mem_1r1w: behavioural 1R1W word memory with a registered (1-cycle) read.
module ascon_msg_mem_1r1w #(
  parameter int DEPTH = 32,
  parameter int W = 32,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/ascon_msg_buf.sv
// ascon_msg_buf: Wishbone-loaded message buffer serving 64-bit blocks to an ASCON core with in-place ciphertext writeback.
// Define ASCON_MSG_BUF_PARITY_EN to add an even-parity bit per word and the sticky parity_err output.
module ascon_msg_buf
  import ascon_msg_buf_pkg::*;
#(
  parameter int WB_DW = 32,
  parameter int DEPTH = 32,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int LEN_W = 8
) (
  input  logic              clk,
  input  logic              nRST,
  input  logic              wb_we,
  input  logic              wb_re,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [WB_DW-1:0]  wb_datain,
  output logic [WB_DW-1:0]  wb_dataout,
  output logic              wb_ack,
  input  logic [LEN_W-1:0]  datalen,
  input  logic              start,
  output logic              busy,
  output logic              len_err,
  input  logic              blk_req,
  output logic [63:0]       blk_data,
  output logic [3:0]        blk_size,
  output logic              blk_last,
  output logic              blk_valid,
  input  logic              ct_valid,
  input  logic [63:0]       ct_data,
  output logic              ct_ready,
`ifdef ASCON_MSG_BUF_PARITY_EN
  output logic              parity_err,
`endif
  output logic              done
);
`ifdef ASCON_MSG_BUF_PARITY_EN
  localparam int MW = WB_DW + 1;
`else
  localparam int MW = WB_DW;
`endif
  localparam int MAX_LEN = DEPTH / WORDS_PER_BLK * BYTES_PER_BLK - 1;
  state_e state_q, state_d;
  logic [ADDR_W-2:0] k_q;
  logic [LEN_W-1:0] len_q;
  logic [WB_DW-1:0] hi_q;
  logic [63:0] ct_q;
  logic [3:0] blk_size_q;
  logic busy_q, len_err_q, wb_ack_q, wb_rd_q, blk_last_q, blk_valid_q, ct_ready_q, done_q;
  logic idle, last_blk, start_ok, mem_we, mem_re;
  logic [ADDR_W-1:0] mem_waddr, mem_raddr;
  logic [WB_DW-1:0] wdata;
  logic [MW-1:0] mem_wdata, mem_rdata;
  assign idle = state_q == IDLE;
  assign last_blk = 32'(k_q) == 32'(len_q[LEN_W-1:3]);
  assign start_ok = idle && start && (32'(datalen) <= 32'(MAX_LEN));
  // Wishbone owns both memory ports in IDLE; the sequencer owns them otherwise.
  assign mem_we = nRST && (idle ? wb_we : (state_q == WR_HI || state_q == WR_LO));
  assign mem_waddr = idle ? wb_addr : {k_q, state_q == WR_LO};
  assign wdata = idle ? wb_datain : (state_q == WR_HI ? ct_q[63:32] : ct_q[31:0]);
  assign mem_re = idle ? (wb_re && !wb_we) : (state_q == RD_HI || state_q == RD_LO);
  assign mem_raddr = idle ? wb_addr : {k_q, state_q == RD_LO};
`ifdef ASCON_MSG_BUF_PARITY_EN
  assign mem_wdata = {^wdata, wdata};
`else
  assign mem_wdata = wdata;
`endif
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     state_d = start_ok ? WAIT_REQ : IDLE;
      WAIT_REQ: state_d = blk_req ? RD_HI : WAIT_REQ;
      RD_HI:    state_d = RD_LO;
      RD_LO:    state_d = HOLD;
      HOLD:     state_d = ct_valid ? WR_HI : HOLD;
      WR_HI:    state_d = WR_LO;
      WR_LO:    state_d = last_blk ? IDLE : WAIT_REQ;
      default:  state_d = IDLE;
    endcase
  end
  ascon_msg_mem_1r1w #(.DEPTH(DEPTH), .W(MW), .AW(ADDR_W)) u_mem (
    .clk(clk), .we(mem_we), .waddr(mem_waddr), .wdata(mem_wdata),
    .re(mem_re), .raddr(mem_raddr), .rdata(mem_rdata)
  );
`ifdef ASCON_MSG_BUF_PARITY_EN
  logic rd_vld_q, parity_err_q;
  always_ff @(posedge clk) begin
    if (!nRST) begin
      rd_vld_q <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      rd_vld_q <= mem_re;
      if (rd_vld_q && ^mem_rdata) parity_err_q <= 1'b1;
    end
  end
  assign parity_err = parity_err_q;
`endif
  always_ff @(posedge clk) begin
    if (!nRST) begin
      state_q <= IDLE;
      k_q <= '0;
      len_q <= '0;
      hi_q <= '0;
      ct_q <= '0;
      blk_size_q <= '0;
      {busy_q, len_err_q, wb_ack_q, wb_rd_q, blk_last_q, blk_valid_q, ct_ready_q, done_q} <= '0;
    end else begin
      state_q <= state_d;
      wb_ack_q <= idle && (wb_we || wb_re);
      wb_rd_q <= idle && mem_re;
      ct_ready_q <= state_q == WR_HI;
      done_q <= state_q == WR_LO && last_blk;
      if (idle && start) len_err_q <= !start_ok;
      if (start_ok) begin
        len_q <= datalen;
        k_q <= '0;
        busy_q <= 1'b1;
      end
      // Low word stays parked in the memory read register for the whole HOLD.
      if (state_q == RD_LO) begin
        hi_q <= mem_rdata[WB_DW-1:0];
        blk_valid_q <= 1'b1;
        blk_size_q <= blk_size_f(last_blk, len_q[2:0]);
        blk_last_q <= last_blk;
      end
      if (state_q == HOLD && ct_valid) begin
        ct_q <= ct_data;
        blk_valid_q <= 1'b0;
      end
      if (state_q == WR_LO) begin
        if (last_blk) busy_q <= 1'b0;
        else k_q <= k_q + 1'b1;
      end
    end
  end
  assign wb_ack = wb_ack_q;
  assign wb_dataout = wb_rd_q ? mem_rdata[WB_DW-1:0] : '0;
  assign busy = busy_q;
  assign len_err = len_err_q;
  assign blk_data = blk_valid_q ? ({hi_q, mem_rdata[WB_DW-1:0]} & blk_mask(blk_size_q)) : '0;
  assign blk_size = blk_size_q;
  assign blk_last = blk_last_q;
  assign blk_valid = blk_valid_q;
  assign ct_ready = ct_ready_q;
  assign done = done_q;
endmodule

// File: tb/tb_ascon_msg_buf.sv
// tb_ascon_msg_buf: table-driven and scoreboarded bench for the ASCON message buffer.
module tb_ascon_msg_buf;
  logic clk = 1'b0, nRST = 1'b0;
  logic wb_we = 0, wb_re = 0, start = 0, blk_req = 0, ct_valid = 0;
  logic [4:0] wb_addr = '0;
  logic [31:0] wb_datain = '0, wb_dataout;
  logic [7:0] datalen = '0;
  logic [63:0] ct_data = '0, blk_data;
  logic [3:0] blk_size;
  logic wb_ack, busy, len_err, blk_last, blk_valid, ct_ready, done;
`ifdef ASCON_MSG_BUF_PARITY_EN
  logic parity_err;
`endif
  ascon_msg_buf dut (
    .clk(clk), .nRST(nRST), .wb_we(wb_we), .wb_re(wb_re), .wb_addr(wb_addr),
    .wb_datain(wb_datain), .wb_dataout(wb_dataout), .wb_ack(wb_ack),
    .datalen(datalen), .start(start), .busy(busy), .len_err(len_err),
    .blk_req(blk_req), .blk_data(blk_data), .blk_size(blk_size), .blk_last(blk_last),
    .blk_valid(blk_valid), .ct_valid(ct_valid), .ct_data(ct_data), .ct_ready(ct_ready),
`ifdef ASCON_MSG_BUF_PARITY_EN
    .parity_err(parity_err),
`endif
    .done(done)
  );
  always #5 clk = ~clk;
  typedef struct packed {logic [63:0] data; logic [3:0] size; logic last;} blk_t;
  typedef struct {int len; bit err; int nblk; int last_size;} sess_t;
  typedef struct {bit we; bit re; logic [4:0] addr; logic [31:0] d; bit ack; bit chk; logic [31:0] dout;} wb_t;
  blk_t sb[$];
  sess_t sv[8];
  wb_t wv[7];
  logic [31:0] mem_m [32];
  int tests = 0, fails = 0;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask
  function automatic logic [63:0] model_blk(input int k, input int size);
    logic [63:0] d = {mem_m[2*k], mem_m[2*k+1]};
    for (int b = 0; b < 8; b++) if (b >= size) d[63-8*b -: 8] = 8'h00;
    return d;
  endfunction
  task automatic wb_write(input int a, input logic [31:0] d);
    wb_we = 1; wb_addr = 5'(a); wb_datain = d;
    tick;
    wb_we = 0;
    chk("wb_wr_ack", 64'(wb_ack), 1);
    mem_m[a] = d;
  endtask
  task automatic wb_read(input int a);
    wb_re = 1; wb_addr = 5'(a);
    tick;
    wb_re = 0;
    chk("wb_rd_ack", 64'(wb_ack), 1);
    chk($sformatf("wb_rd[%0d]", a), 64'(wb_dataout), 64'(mem_m[a]));
  endtask
  task automatic start_sess(input int len);
    start = 1; datalen = 8'(len);
    tick;
    start = 0;
  endtask
  task automatic do_block(input int k, input logic [63:0] exp_d, input int size, input bit last, input logic [63:0] ct);
    blk_t e;
    int n;
    sb.push_back(blk_t'{exp_d, 4'(size), last});
    blk_req = 1;
    tick;
    blk_req = 0;
    n = 1;
    while (!blk_valid && n < 10) begin tick; n++; end
    chk("blk_latency", 64'(n), 3);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk($sformatf("blk%0d_data", k), blk_data, e.data);
      chk($sformatf("blk%0d_size", k), 64'(blk_size), 64'(e.size));
      chk($sformatf("blk%0d_last", k), 64'(blk_last), 64'(e.last));
    end
    blk_req = 1;
    tick;
    blk_req = 0;
    chk("hold_stable", {63'(0), blk_valid} ^ blk_data, {63'(0), 1'b1} ^ exp_d);
    ct_valid = 1; ct_data = ct;
    tick;
    ct_valid = 0;
    chk("wr_hi_valid", 64'(blk_valid), 0);
    n = 1;
    while (!ct_ready && n < 10) begin tick; n++; end
    chk("ct_ready_lat", 64'(n), 2);
    mem_m[2*k] = ct[63:32];
    mem_m[2*k+1] = ct[31:0];
    tick;
    chk("done_pulse", 64'(done), 64'(last));
    chk("busy_after_blk", 64'(busy), 64'(!last));
    if (last) begin
      tick;
      chk("done_one_cycle", 64'(done), 0);
    end
  endtask
  task automatic run_session(input sess_t s);
    start_sess(s.len);
    chk($sformatf("len_err(%0d)", s.len), 64'(len_err), 64'(s.err));
    chk($sformatf("busy(%0d)", s.len), 64'(busy), 64'(!s.err));
    for (int k = 0; k < s.nblk; k++) begin
      int size = (k == s.nblk - 1) ? s.last_size : 8;
      do_block(k, model_blk(k, size), size, k == s.nblk - 1, {$urandom, $urandom});
    end
  endtask
  initial begin
    sv[0] = '{12, 0, 2, 4};
    sv[1] = '{16, 0, 3, 0};
    sv[2] = '{0, 0, 1, 0};
    sv[3] = '{128, 1, 0, 0};
    sv[4] = '{127, 0, 16, 7};
    sv[5] = '{200, 1, 0, 0};
    sv[6] = '{8, 0, 2, 0};
    sv[7] = '{7, 0, 1, 7};
    wv[0] = '{1, 0, 3, 32'hDEADBEEF, 1, 0, 0};
    wv[1] = '{0, 1, 3, 0, 1, 1, 32'hDEADBEEF};
    wv[2] = '{0, 0, 3, 0, 0, 1, 0};
    wv[3] = '{1, 0, 7, 32'hCAFEF00D, 1, 0, 0};
    wv[4] = '{1, 1, 7, 32'h12345678, 1, 0, 0};
    wv[5] = '{0, 1, 7, 0, 1, 1, 32'h12345678};
    wv[6] = '{0, 1, 3, 0, 1, 1, 32'hDEADBEEF};
    repeat (3) tick;
    chk("rst_busy", 64'(busy), 0);
    chk("rst_valid", 64'(blk_valid), 0);
    chk("rst_ack", 64'(wb_ack), 0);
    chk("rst_done", 64'(done), 0);
    chk("rst_blk", blk_data, 0);
    nRST = 1;
    tick;
    foreach (wv[i]) begin
      wb_we = wv[i].we; wb_re = wv[i].re; wb_addr = wv[i].addr; wb_datain = wv[i].d;
      tick;
      wb_we = 0; wb_re = 0;
      chk($sformatf("wbv%0d_ack", i), 64'(wb_ack), 64'(wv[i].ack));
      if (wv[i].chk) chk($sformatf("wbv%0d_dout", i), 64'(wb_dataout), 64'(wv[i].dout));
    end
    for (int i = 0; i < 32; i++) wb_write(i, $urandom);
    wb_write(0, 32'h00010203);
    wb_write(1, 32'h04050607);
    wb_write(2, 32'h08090A0B);
    wb_write(3, 32'h0C0D0E0F);
    start_sess(12);
    chk("s12_busy", 64'(busy), 1);
    do_block(0, 64'h0001020304050607, 8, 0, 64'h1122334455667788);
    do_block(1, 64'h08090A0B00000000, 4, 1, 64'h08090A0B0C0D0E0F);
    wb_read(0);
    chk("ct_word0", 64'(wb_dataout), 64'h11223344);
    wb_read(1);
    chk("ct_word1", 64'(wb_dataout), 64'h55667788);
    foreach (sv[i]) run_session(sv[i]);
    start_sess(0);
    wb_we = 1; wb_addr = 9; wb_datain = ~mem_m[9];
    tick;
    wb_we = 0;
    chk("busy_wr_noack", 64'(wb_ack), 0);
    wb_re = 1;
    tick;
    wb_re = 0;
    chk("busy_rd_noack", 64'(wb_ack), 0);
    do_block(0, 64'h0, 0, 1, {mem_m[0], mem_m[1]});
    wb_read(9);
    start_sess(12);
    blk_req = 1;
    tick;
    blk_req = 0;
    repeat (2) tick;
    chk("pre_rst_valid", 64'(blk_valid), 1);
    nRST = 0;
    tick;
    nRST = 1;
    chk("mid_rst_busy", 64'(busy), 0);
    chk("mid_rst_valid", 64'(blk_valid), 0);
    chk("mid_rst_done", 64'(done), 0);
    tick;
    chk("mid_rst_done2", 64'(done), 0);
    run_session(sv[0]);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
